// File: rtl/axi_read_arbiter_if.sv
// Bundle of requester-side, interconnect-side and status signals of axi_read_arbiter.
// master: the arbiter's view; slave: the surroundings (requesters, interconnect, monitor).
interface axi_read_arbiter_if;
    logic [31:0] S0_ARADDR;
    logic [7:0]  S0_ARLEN;
    logic        S0_ARVALID;
    logic        S0_ARREADY;
    logic [31:0] S0_RDATA;
    logic [1:0]  S0_RRESP;
    logic        S0_RLAST;
    logic        S0_RVALID;
    logic        S0_RREADY;

    logic [31:0] S1_ARADDR;
    logic [7:0]  S1_ARLEN;
    logic        S1_ARVALID;
    logic        S1_ARREADY;
    logic [31:0] S1_RDATA;
    logic [1:0]  S1_RRESP;
    logic        S1_RLAST;
    logic        S1_RVALID;
    logic        S1_RREADY;

    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic        M_AXI_RID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    logic        GRANT;
    logic        BUSY;
    logic        LEN_ERR;

    modport master (
        input  S0_ARADDR, S0_ARLEN, S0_ARVALID, S0_RREADY,
        output S0_ARREADY, S0_RDATA, S0_RRESP, S0_RLAST, S0_RVALID,
        input  S1_ARADDR, S1_ARLEN, S1_ARVALID, S1_RREADY,
        output S1_ARREADY, S1_RDATA, S1_RRESP, S1_RLAST, S1_RVALID,
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output GRANT, BUSY, LEN_ERR
    );

    modport slave (
        output S0_ARADDR, S0_ARLEN, S0_ARVALID, S0_RREADY,
        input  S0_ARREADY, S0_RDATA, S0_RRESP, S0_RLAST, S0_RVALID,
        output S1_ARADDR, S1_ARLEN, S1_ARVALID, S1_RREADY,
        input  S1_ARREADY, S1_RDATA, S1_RRESP, S1_RLAST, S1_RVALID,
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  GRANT, BUSY, LEN_ERR
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI4 read arbiter sharing one AR/R master port, one burst at a time.
// Build option ARB_FIXED_PRIORITY_EN: requester 0 always wins ties (default is round-robin).
module axi_read_arbiter #(
    parameter logic [2:0] AR_SIZE  = 3'b010,
    parameter logic [1:0] AR_BURST = 2'b01
) (
    input  logic               CLK,
    input  logic               RST,
    axi_read_arbiter_if.master bus
);
    // state | meaning
    // IDLE  | no burst outstanding; arbitrate pending requests
    // ADDR  | M_AXI_ARVALID held stable until the interconnect accepts it
    // DATA  | R beats routed to the granted requester until RLAST
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic        arvalid_q;
    logic        grant_q;
    logic        len_err_q;
    logic [8:0]  beat_cnt;
    logic        req_any;
    logic        winner;
    logic        ar_hs;
    logic        r_beat;
    logic        granted_rready;
    logic        unused_rid;

    assign req_any        = bus.S0_ARVALID | bus.S1_ARVALID;
    assign ar_hs          = (state == ADDR) & bus.M_AXI_ARREADY;
    assign granted_rready = grant_q ? bus.S1_RREADY : bus.S0_RREADY;
    assign r_beat         = (state == DATA) & bus.M_AXI_RVALID & granted_rready;
    assign unused_rid     = bus.M_AXI_RID;

`ifdef ARB_FIXED_PRIORITY_EN
    assign winner = ~bus.S0_ARVALID;
`else
    logic last_q;

    // On a tie the requester that did not finish most recently wins.
    assign winner = (bus.S0_ARVALID & bus.S1_ARVALID) ? ~last_q : bus.S1_ARVALID;

    always_ff @(posedge CLK) begin
        if (RST)
            last_q <= 1'b1;
        else if (r_beat && bus.M_AXI_RLAST)
            last_q <= grant_q;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = ADDR;
            ADDR:    if (bus.M_AXI_ARREADY) state_nxt = DATA;
            DATA:    if (r_beat && bus.M_AXI_RLAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            grant_q   <= 1'b0;
            len_err_q <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                araddr_q  <= winner ? bus.S1_ARADDR : bus.S0_ARADDR;
                arlen_q   <= winner ? bus.S1_ARLEN : bus.S0_ARLEN;
                arvalid_q <= 1'b1;
                grant_q   <= winner;
            end
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                beat_cnt  <= '0;
            end
            // beat_cnt holds the index of the beat being transferred
            if (r_beat) begin
                beat_cnt <= beat_cnt + 9'd1;
                if (bus.M_AXI_RLAST && (beat_cnt != {1'b0, arlen_q}))
                    len_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.S0_ARREADY   = 1'b0;
        bus.S1_ARREADY   = 1'b0;
        bus.S0_RVALID    = 1'b0;
        bus.S0_RDATA     = '0;
        bus.S0_RRESP     = '0;
        bus.S0_RLAST     = 1'b0;
        bus.S1_RVALID    = 1'b0;
        bus.S1_RDATA     = '0;
        bus.S1_RRESP     = '0;
        bus.S1_RLAST     = 1'b0;
        bus.M_AXI_RREADY = 1'b0;
        case (state)
            ADDR: begin
                if (bus.M_AXI_ARREADY) begin
                    if (grant_q) bus.S1_ARREADY = 1'b1;
                    else         bus.S0_ARREADY = 1'b1;
                end
            end
            DATA: begin
                bus.M_AXI_RREADY = granted_rready;
                if (grant_q) begin
                    bus.S1_RVALID = bus.M_AXI_RVALID;
                    bus.S1_RDATA  = bus.M_AXI_RDATA;
                    bus.S1_RRESP  = bus.M_AXI_RRESP;
                    bus.S1_RLAST  = bus.M_AXI_RLAST;
                end else begin
                    bus.S0_RVALID = bus.M_AXI_RVALID;
                    bus.S0_RDATA  = bus.M_AXI_RDATA;
                    bus.S0_RRESP  = bus.M_AXI_RRESP;
                    bus.S0_RLAST  = bus.M_AXI_RLAST;
                end
            end
            default: ;
        endcase
    end

    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARLEN   = arlen_q;
    assign bus.M_AXI_ARSIZE  = AR_SIZE;
    assign bus.M_AXI_ARBURST = AR_BURST;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.GRANT         = grant_q;
    assign bus.BUSY          = (state != IDLE);
    assign bus.LEN_ERR       = len_err_q;
endmodule
